// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and FSM state encodings.
package lsu_rmw_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_rmw_align.sv
// Combinational lane logic: extracts/extends sub-word load data and merges
// sub-word store data into a read word. Only the low half of the store data
// can ever reach memory through a merge, so only that half is an input.
module lsu_rmw_align
  import lsu_rmw_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed lane and apply sign/zero extension for loads.
  always_comb begin
    case (addr)
      2'd0:    ld_byte = word[7:0];
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = word;
    endcase
  end

  // Replace only the addressed byte/half lane; every other bit keeps the read value.
  always_comb begin
    st_word = word;
    if (funct3 == F3_B) begin
      case (addr)
        2'd0:    st_word[7:0]   = wdata[7:0];
        2'd1:    st_word[15:8]  = wdata[7:0];
        2'd2:    st_word[23:16] = wdata[7:0];
        default: st_word[31:24] = wdata[7:0];
      endcase
    end else if (funct3 == F3_H) begin
      if (addr[1]) st_word[31:16] = wdata;
      else         st_word[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide data memory with a 1-cycle registered
// read. Sub-word stores are done as read-modify-write.
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no
// back-pressure; rsp_rdata/rsp_err hold until the next response.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  lsu_state_e          state_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [2:0]          f3_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merge_q;

  logic                req_fire;
  logic                req_bad;
  logic [31:0]         ld_data;
  logic [31:0]         st_word;

  assign req_fire  = req_valid && req_ready;
  assign req_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // Classify the incoming request; any hit sends it straight to RESP with no memory access.
  always_comb begin
    req_bad = 1'b0;
    if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111))
      req_bad = 1'b1;
    if (req_we && req_funct3[2])
      req_bad = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0)
      req_bad = 1'b1;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      req_bad = 1'b1;
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
  end

  lsu_rmw_align u_align (
    .word    (mem_dout),
    .addr    (addr_q[1:0]),
    .funct3  (f3_q),
    .wdata   (wdata_q[15:0]),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Memory drive comes only from latched request fields; reset kills any write in flight.
  assign mem_addr = addr_q[ADDR_W+1:2];
  assign mem_din  = (state_q == ST_WRITE) ? merge_q : wdata_q;
  assign mem_we   = ~rst && (((state_q == ST_ACCESS) && we_q && (f3_q == F3_W)) ||
                             (state_q == ST_WRITE));

  // Request FSM with request latches, merge register and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            addr_q  <= req_addr[ADDR_W+1:0];
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_bad) begin
              state_q   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (we_q && (f3_q == F3_W)) begin
            state_q   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (we_q) begin
            merge_q <= st_word;
            state_q <= ST_WRITE;
          end else begin
            state_q   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
            rsp_err   <= 1'b0;
          end
        end
        ST_WRITE: begin
          state_q   <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural data memory.
module tb_lsu_rmw;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [2:0]        dbg_state;

  logic [31:0]       dmem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  int edge_cnt = 0;
  int we_total = 0;
  int we_edge  = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  lsu_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // data memory: 1-cycle registered read, write counter
  always @(posedge clk) begin
    if (pre_we) begin
      dmem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_din;
      we_total <= we_total + 1;
      we_edge  <= edge_cnt;
    end
    mem_dout <= dmem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // driver: issue one request and wait for its response
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int we_cyc, output int n_we);
    int w0;
    int start;
    int guard;
    w0 = we_total;
    rdata = 32'd0; err = 1'b0; lat = -1;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check_val("accept_timeout", 32'd0, 32'd1);
    start = edge_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = edge_cnt - start;
        rdata = rsp_rdata;
        err = rsp_err;
        break;
      end
    end
    if (lat < 0) check_val("rsp_timeout", 32'd0, 32'd1);
    n_we = we_total - w0;
    we_cyc = we_edge - start;
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input int exp_nwe, input int exp_wecyc);
    logic [31:0] rdata;
    logic        err;
    int          lat, we_cyc, n_we;
    do_req(we, f3, addr, wdata, rdata, err, lat, we_cyc, n_we);
    check_val({tag, "_rdata"}, rdata, exp_data);
    check_val({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_nwe"}, n_we, exp_nwe);
    if (exp_nwe > 0) check_val({tag, "_wecyc"}, we_cyc, exp_wecyc);
  endtask

  initial begin
    int w0, start, n_rsp, ready_cnt, last_rsp, idx, rsp_seen;
    logic acc;

    // reset with memory preload
    for (int i = 0; i < 24; i++) preload(i[ADDR_W-1:0], 32'd0);
    preload(12'd5,  32'h8899AABB);
    preload(12'd8,  32'h11223344);
    preload(12'd12, 32'hA0A0A0A0);
    preload(12'd13, 32'hB1B1B1B1);
    preload(12'd14, 32'hC2C2C2C2);
    preload(12'd15, 32'hD3D3D3D3);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready",  {31'd0, req_ready}, 32'd1);
    check_val("rst_valid",  {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rdata",  rsp_rdata, 32'd0);
    check_val("rst_err",    {31'd0, rsp_err}, 32'd0);
    check_val("rst_memadr", {20'd0, mem_addr}, 32'd0);

    // sub-word and word loads from word 5
    run_chk("lb17",  1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0, 0);
    run_chk("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h00000088, 1'b0, 3, 0, 0);
    run_chk("lh16",  1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 0);
    run_chk("lhu14", 1'b0, 3'b101, 32'h14, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 0);
    run_chk("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 0);

    // read-modify-write stores
    run_chk("sb15", 1'b1, 3'b000, 32'h15, 32'h123456CC, 32'h0, 1'b0, 4, 1, 3);
    check_val("sb15_mem", dmem[5], 32'h8899CCBB);
    run_chk("sh16", 1'b1, 3'b001, 32'h16, 32'hABCD7777, 32'h0, 1'b0, 4, 1, 3);
    check_val("sh16_mem", dmem[5], 32'h7777CCBB);
    run_chk("lb16", 1'b0, 3'b000, 32'h16, 32'h0, 32'h00000077, 1'b0, 3, 0, 0);

    // full-word store then read back
    run_chk("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1);
    check_val("sw40_mem", dmem[16], 32'hDEADBEEF);
    run_chk("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 0);

    // error cases: no write, 1-cycle response, rdata cleared
    run_chk("e_lw02",   1'b0, 3'b010, 32'h02,   32'h0,        32'h0, 1'b1, 1, 0, 0);
    run_chk("e_sh01",   1'b1, 3'b001, 32'h01,   32'h0000FFFF, 32'h0, 1'b1, 1, 0, 0);
    run_chk("e_lb4000", 1'b0, 3'b000, 32'h4000, 32'h0,        32'h0, 1'b1, 1, 0, 0);
    run_chk("e_f3_011", 1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1, 1, 0, 0);
    run_chk("e_sbu",    1'b1, 3'b100, 32'h14,   32'h0,        32'h0, 1'b1, 1, 0, 0);
    check_val("err_mem5",  dmem[5],  32'h7777CCBB);
    check_val("err_mem4",  dmem[4],  32'h0);
    check_val("err_mem0",  dmem[0],  32'h0);

    // reset during the WRITE cycle of an SH to 0x20
    w0 = we_total;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h00005555;
    req_valid = 1'b1;
    start = edge_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_val("rw_cycle", edge_cnt - start, 3);
    check_val("rw_state", {29'd0, dbg_state}, 32'd3);
    rst = 1'b1;
    #1 check_val("rw_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rw_ready", {31'd0, req_ready}, 32'd1);
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    check_val("rw_no_rsp", rsp_seen, 0);
    check_val("rw_no_we",  we_total - w0, 0);
    check_val("rw_mem8",   dmem[8], 32'h11223344);

    // back-to-back loads with req_valid held high
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A0A0A0 + 32'h11111111 * i);
    @(posedge clk);
    #1;
    idx = 0; n_rsp = 0; ready_cnt = 0; last_rsp = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30; req_valid = 1'b1;
    for (int t = 0; t < 60 && n_rsp < 4; t++) begin
      @(negedge clk);
      if (req_ready) ready_cnt++;
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        if (exp_q.size() > 0) check_val("b2b_data", rsp_rdata, exp_q.pop_front());
        else check_val("b2b_extra", 32'd1, 32'd0);
        if (n_rsp > 0) check_val("b2b_gap", edge_cnt - last_rsp, 4);
        last_rsp = edge_cnt;
        n_rsp++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) req_addr = 32'h30 + 32'd4 * idx;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check_val("b2b_count", n_rsp, 4);
    check_val("b2b_ready", ready_cnt, 4);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
